// File: rtl/mem_stage.sv
// Memory pipeline stage: issues one data-memory request per load/store and holds it until acked,
// then loads the WB register; non-memory ops pass through in one cycle.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [31:0] ALUResult,
  input  logic [31:0] StoreData,
  input  logic [4:0]  WriteReg,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemToReg,
  input  logic        RegWrite,
  input  logic [1:0]  MemSize,
  input  logic        MemUnsigned,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [31:0] ALUResultOut,
  output logic [31:0] MemData,
  output logic [4:0]  WriteRegOut,
  output logic        MemToRegOut,
  output logic        RegWriteOut,
  output logic        mem_stall,
  output logic        mem_misaligned
);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;
  state_t state, state_nxt;

  logic        is_mem, misaligned, go_req;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [1:0]  cap_size;
  logic        cap_uns, cap_m2r, cap_rw;
  logic [4:0]  cap_wreg;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_val;

  assign is_mem = ex_valid & (MemRead | MemWrite);

  always_comb begin
    case (MemSize)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = ALUResult[0];
      default: misaligned = |ALUResult[1:0];
    endcase
  end

  assign go_req = is_mem & ~misaligned;

  // Store lanes: narrow data is replicated so the byte enables alone pick the target lane.
  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = StoreData;
    case (MemSize)
      2'b00: begin
        be_calc    = 4'b0001 << ALUResult[1:0];
        wdata_calc = {4{StoreData[7:0]}};
      end
      2'b01: begin
        be_calc    = ALUResult[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{StoreData[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (dmem_addr[1:0])
      2'b00:   load_byte = dmem_rdata[7:0];
      2'b01:   load_byte = dmem_rdata[15:8];
      2'b10:   load_byte = dmem_rdata[23:16];
      default: load_byte = dmem_rdata[31:24];
    endcase
    load_half = dmem_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (cap_size)
      2'b00:   load_val = cap_uns ? {24'b0, load_byte} : {{24{load_byte[7]}}, load_byte};
      2'b01:   load_val = cap_uns ? {16'b0, load_half} : {{16{load_half[15]}}, load_half};
      default: load_val = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go_req)   state_nxt = REQ;
      REQ:     if (dmem_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dmem_req  = (state == REQ);
    mem_stall = ((state == IDLE) & go_req) | ((state == REQ) & ~dmem_ack);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_wdata     <= '0;
      dmem_be        <= '0;
      cap_size       <= '0;
      cap_uns        <= 1'b0;
      cap_wreg       <= '0;
      cap_m2r        <= 1'b0;
      cap_rw         <= 1'b0;
      wb_valid       <= 1'b0;
      ALUResultOut   <= '0;
      MemData        <= '0;
      WriteRegOut    <= '0;
      MemToRegOut    <= 1'b0;
      RegWriteOut    <= 1'b0;
      mem_misaligned <= 1'b0;
    end else begin
      mem_misaligned <= 1'b0;
      if (state == IDLE) begin
        if (go_req) begin
          dmem_we    <= MemWrite;
          dmem_addr  <= ALUResult;
          dmem_wdata <= wdata_calc;
          dmem_be    <= be_calc;
          cap_size   <= MemSize;
          cap_uns    <= MemUnsigned;
          cap_wreg   <= WriteReg;
          cap_m2r    <= MemToReg;
          cap_rw     <= RegWrite;
          wb_valid   <= 1'b0;
        end else if (is_mem) begin
          wb_valid       <= 1'b0;
          RegWriteOut    <= 1'b0;
          mem_misaligned <= 1'b1;
        end else if (ex_valid) begin
          wb_valid     <= 1'b1;
          ALUResultOut <= ALUResult;
          MemData      <= '0;
          WriteRegOut  <= WriteReg;
          MemToRegOut  <= MemToReg;
          RegWriteOut  <= RegWrite;
        end else begin
          wb_valid    <= 1'b0;
          RegWriteOut <= 1'b0;
        end
      end else if (dmem_ack) begin
        wb_valid     <= 1'b1;
        ALUResultOut <= dmem_addr;
        MemData      <= dmem_we ? 32'b0 : load_val;
        WriteRegOut  <= cap_wreg;
        MemToRegOut  <= cap_m2r;
        RegWriteOut  <= cap_rw;
      end
    end
  end

endmodule
